// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply and 32/32 divide, one iteration per cycle.
// Results land in HI/LO; a divide by zero is flagged without touching them.
module mult_div_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic          fix_stage;
    logic          is_div;
    logic          dz;
    logic          neg_res;
    logic          neg_rem;
    logic [63:0]   acc;
    logic [63:0]   mcand;
    logic [31:0]   mplier;
    logic [31:0]   rem;
    logic [31:0]   quo;
    logic [31:0]   divisor;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

    logic          accept_mult;
    logic          accept_div;
    logic          accept_dz;
    logic          commit;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [32:0]   shifted;
    logic [32:0]   diff;
    logic          ge;
    logic [63:0]   prod_fix;
    logic [31:0]   quo_fix;
    logic [31:0]   rem_fix;

    // A simultaneous multiply request wins; divide with zero divisor skips CALC.
    assign accept_mult = (state == IDLE) && start_mult;
    assign accept_div  = (state == IDLE) && !start_mult && start_div && (op_b != 32'd0);
    assign accept_dz   = (state == IDLE) && !start_mult && start_div && (op_b == 32'd0);

    assign mag_a = op_a[31] ? (~op_a + 32'd1) : op_a;
    assign mag_b = op_b[31] ? (~op_b + 32'd1) : op_b;

    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, divisor};
    assign ge      = !diff[32];

    assign prod_fix = neg_res ? (~acc + 64'd1) : acc;
    assign quo_fix  = neg_res ? (~quo + 32'd1) : quo;
    assign rem_fix  = neg_rem ? (~rem + 32'd1) : rem;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_mult || accept_div) state_next = CALC;
                else if (accept_dz)            state_next = FINISH;
            end
            CALC:    if (count == LAST) state_next = FINISH;
            FINISH:  if (fix_stage)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        commit = (state == FINISH) && fix_stage;
    end

    // FINISH first registers the sign-corrected result, then commits it to HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            fix_stage <= 1'b0;
            is_div    <= 1'b0;
            dz        <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            res_hi    <= '0;
            res_lo    <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done     <= commit;
            div_zero <= commit && dz;
            case (state)
                IDLE: begin
                    fix_stage <= 1'b0;
                    count     <= '0;
                    if (accept_mult || accept_div) begin
                        is_div  <= accept_div;
                        dz      <= 1'b0;
                        neg_res <= op_a[31] ^ op_b[31];
                        neg_rem <= op_a[31];
                        acc     <= '0;
                        mcand   <= {32'd0, mag_a};
                        mplier  <= mag_b;
                        rem     <= '0;
                        quo     <= mag_a;
                        divisor <= mag_b;
                    end else if (accept_dz) begin
                        dz <= 1'b1;
                    end
                end
                CALC: begin
                    count <= count + CW'(1);
                    if (is_div) begin
                        rem <= ge ? diff[31:0] : shifted[31:0];
                        quo <= {quo[30:0], ge};
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= {mcand[62:0], 1'b0};
                        mplier <= {1'b0, mplier[31:1]};
                    end
                end
                FINISH: begin
                    if (!fix_stage) begin
                        fix_stage <= 1'b1;
                        res_hi    <= is_div ? rem_fix : prod_fix[63:32];
                        res_lo    <= is_div ? quo_fix : prod_fix[31:0];
                    end else begin
                        fix_stage <= 1'b0;
                        if (!dz) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
                default: fix_stage <= 1'b0;
            endcase
        end
    end

endmodule
